// File: rtl/score_sequencer.sv
// Register-frame playback engine: stores NUM_CH x DEPTH frames and plays them back
// one step per TICK_DIV clocks, with a one-cycle trigger pulse on each step entry.
module score_sequencer #(
  parameter int NUM_CH   = 4,
  parameter int FRAME_W  = 32,
  parameter int DEPTH    = 1024,
  parameter int TICK_DIV = 262144,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(NUM_CH),
  localparam int TW = $clog2(TICK_DIV)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      wr_en,
  input  logic [CW-1:0]             wr_ch,
  input  logic [AW-1:0]             wr_addr,
  input  logic [FRAME_W-1:0]        wr_data,
  input  logic                      play,
  input  logic                      stop,
  input  logic                      loop_en,
  input  logic [AW-1:0]             end_step,
  output logic [NUM_CH*FRAME_W-1:0] frames_out,
  output logic [NUM_CH-1:0]         trigger_out,
  output logic [AW-1:0]             step_out,
  output logic                      busy,
  output logic                      done
);

  typedef enum logic [1:0] {IDLE, FETCH, APPLY, HOLD} state_t;

  state_t                    state_reg;
  logic [AW-1:0]             end_latched_reg;
  logic [TW-1:0]             tick_reg;
  logic [NUM_CH*FRAME_W-1:0] fetched_frames;
  logic [NUM_CH-1:0]         fetched_flags;

  // One block RAM per channel; the read port only moves during FETCH so the
  // captured frame stays put while APPLY consumes it.
  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [FRAME_W-1:0] mem [DEPTH];
      logic [FRAME_W-1:0] rd_reg;

      always_ff @(posedge clk) begin
        if (wr_en && wr_ch == CW'(gi))
          mem[wr_addr] <= wr_data;
        if (state_reg == FETCH)
          rd_reg <= mem[step_out];
      end

      assign fetched_frames[gi*FRAME_W +: FRAME_W] = {1'b0, rd_reg[FRAME_W-2:0]};
      assign fetched_flags[gi] = rd_reg[FRAME_W-1];
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg       <= IDLE;
      end_latched_reg <= '0;
      tick_reg        <= '0;
      frames_out      <= '0;
      trigger_out     <= '0;
      step_out        <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
    end else begin
      done        <= 1'b0;
      trigger_out <= '0;
      if (stop && state_reg != IDLE) begin
        state_reg  <= IDLE;
        tick_reg   <= '0;
        frames_out <= '0;
        step_out   <= '0;
        busy       <= 1'b0;
      end else begin
        case (state_reg)
          IDLE: begin
            if (play && !stop) begin
              state_reg       <= FETCH;
              step_out        <= '0;
              end_latched_reg <= end_step;
              busy            <= 1'b1;
            end
          end
          FETCH: state_reg <= APPLY;
          APPLY: begin
            frames_out  <= fetched_frames;
            trigger_out <= fetched_flags;
            tick_reg    <= '0;
            state_reg   <= HOLD;
          end
          HOLD: begin
            // Deciding at TICK_DIV-3 leaves FETCH and APPLY to fill out the step period.
            if (tick_reg == TW'(TICK_DIV - 3)) begin
              tick_reg <= '0;
              if (step_out != end_latched_reg) begin
                step_out  <= step_out + AW'(1);
                state_reg <= FETCH;
              end else if (loop_en) begin
                step_out  <= '0;
                state_reg <= FETCH;
              end else begin
                state_reg <= IDLE;
                busy      <= 1'b0;
                done      <= 1'b1;
              end
            end else begin
              tick_reg <= tick_reg + TW'(1);
            end
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_score_sequencer.sv
// Bench for score_sequencer: a time-stamped playback model predicts every cycle's
// outputs into a queue, and a negedge monitor pops and compares them.
module tb_score_sequencer;
  localparam int NUM_CH   = 2;
  localparam int FRAME_W  = 8;
  localparam int DEPTH    = 8;
  localparam int TICK_DIV = 8;
  localparam int AW       = 3;
  localparam int CW       = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                      reset = 1'b0;
  logic                      wr_en = 1'b0;
  logic [CW-1:0]             wr_ch = '0;
  logic [AW-1:0]             wr_addr = '0;
  logic [FRAME_W-1:0]        wr_data = '0;
  logic                      play = 1'b0;
  logic                      stop = 1'b0;
  logic                      loop_en = 1'b0;
  logic [AW-1:0]             end_step = '0;
  logic [NUM_CH*FRAME_W-1:0] frames_out;
  logic [NUM_CH-1:0]         trigger_out;
  logic [AW-1:0]             step_out;
  logic                      busy;
  logic                      done;

  score_sequencer #(
    .NUM_CH(NUM_CH), .FRAME_W(FRAME_W), .DEPTH(DEPTH), .TICK_DIV(TICK_DIV)
  ) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_ch(wr_ch), .wr_addr(wr_addr),
    .wr_data(wr_data), .play(play), .stop(stop), .loop_en(loop_en),
    .end_step(end_step), .frames_out(frames_out), .trigger_out(trigger_out),
    .step_out(step_out), .busy(busy), .done(done)
  );

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [NUM_CH*FRAME_W-1:0] frames;
    logic [NUM_CH-1:0]         trig;
    logic [AW-1:0]             step;
    logic                      busy;
    logic                      done;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: playback described by the cycle numbers at which the next
  // frame is applied and the next step decision falls due.
  logic [FRAME_W-1:0] score [NUM_CH][DEPTH];
  logic [FRAME_W-1:0] fetched [NUM_CH];
  bit     m_busy = 0;
  int     m_step = 0;
  int     m_end = 0;
  longint n = 0;
  longint apply_at = -1;
  longint decide_at = -1;
  exp_t   cur;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy = 0;
      m_step = 0;
      cur.frames = '0;
      cur.trig = '0;
      cur.step = '0;
      cur.busy = 1'b0;
      cur.done = 1'b0;
      exp_q.delete();
      exp_q.push_back(cur);
    end else begin
      n++;
      cur.done = 1'b0;
      cur.trig = '0;
      if (!m_busy) begin
        if (play && !stop) begin
          m_busy = 1;
          m_step = 0;
          m_end = int'(end_step);
          apply_at = n + 2;
          decide_at = -1;
        end
      end else if (stop) begin
        m_busy = 0;
        m_step = 0;
        cur.frames = '0;
      end else begin
        if (n == apply_at - 1)
          for (int ch = 0; ch < NUM_CH; ch++) fetched[ch] = score[ch][m_step];
        if (n == apply_at) begin
          for (int ch = 0; ch < NUM_CH; ch++) begin
            cur.frames[ch*FRAME_W +: FRAME_W] = {1'b0, fetched[ch][FRAME_W-2:0]};
            cur.trig[ch] = fetched[ch][FRAME_W-1];
          end
          decide_at = n + TICK_DIV - 2;
        end
        if (n == decide_at) begin
          if (m_step != m_end) begin
            m_step = (m_step + 1) % DEPTH;
            apply_at = n + 2;
          end else if (loop_en) begin
            m_step = 0;
            apply_at = n + 2;
          end else begin
            m_busy = 0;
            cur.done = 1'b1;
          end
        end
      end
      if (wr_en) score[wr_ch][wr_addr] = wr_data;
      cur.busy = m_busy;
      cur.step = m_step[AW-1:0];
      exp_q.push_back(cur);
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s at t=%0t: got %0h, required %0h", name, $time, act, req);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("frames_out", 64'(frames_out), 64'(e.frames));
      check("trigger_out", 64'(trigger_out), 64'(e.trig));
      check("step_out", 64'(step_out), 64'(e.step));
      check("busy", 64'(busy), 64'(e.busy));
      check("done", 64'(done), 64'(e.done));
    end
  end

  task automatic step_cyc(input int k);
    repeat (k) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic write_frame(input int ch, input int addr, input logic [FRAME_W-1:0] d);
    wr_en = 1'b1;
    wr_ch = CW'(ch);
    wr_addr = AW'(addr);
    wr_data = d;
    step_cyc(1);
    wr_en = 1'b0;
  endtask

  task automatic pulse_play(input int last, input bit lp, input string tag);
    end_step = AW'(last);
    loop_en = lp;
    play = 1'b1;
    $display("[TB] %s: play end_step=%0d loop_en=%0d", tag, last, lp);
    step_cyc(1);
    play = 1'b0;
  endtask

  task automatic wait_idle(input int limit, input string tag);
    int cnt = 0;
    while (busy && cnt < limit) begin
      step_cyc(1);
      cnt++;
    end
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL %s timeout: busy=%b after %0d cycles, required 0", tag, busy, cnt);
    end
  endtask

  initial begin
    logic [FRAME_W-1:0] d;
    #1 reset = 1'b1;
    step_cyc(2);
    reset = 1'b0;
    step_cyc(1);

    // Fill the whole score, then lay down the test-plan steps 0..2.
    for (int s = 0; s < DEPTH; s++)
      for (int ch = 0; ch < NUM_CH; ch++) write_frame(ch, s, FRAME_W'($urandom));
    for (int s = 0; s < 3; s++)
      for (int ch = 0; ch < NUM_CH; ch++) begin
        d = FRAME_W'($urandom) & 8'h7F;
        if (s == 0 && ch == 0) d = d | 8'h80;
        write_frame(ch, s, d);
      end
    $display("[TB] score loaded");

    pulse_play(2, 0, "three-step");
    wait_idle(100, "three-step");
    step_cyc(3);

    pulse_play(2, 1, "loop");
    step_cyc(30);
    loop_en = 1'b0;
    wait_idle(100, "loop-release");
    step_cyc(3);

    play = 1'b1;
    stop = 1'b1;
    $display("[TB] play with stop");
    step_cyc(1);
    play = 1'b0;
    stop = 1'b0;
    step_cyc(4);

    pulse_play(2, 0, "stop-mid-hold");
    step_cyc(12);
    stop = 1'b1;
    step_cyc(1);
    stop = 1'b0;
    step_cyc(3);

    pulse_play(2, 1, "write-while-playing");
    step_cyc(11);
    write_frame(0, 1, FRAME_W'($urandom) | 8'h80);
    step_cyc(30);
    stop = 1'b1;
    step_cyc(1);
    stop = 1'b0;
    step_cyc(3);

    pulse_play(2, 0, "reset-in-fetch");
    step_cyc(16);
    reset = 1'b1;
    step_cyc(1);
    reset = 1'b0;
    step_cyc(2);
    pulse_play(2, 0, "after-reset");
    wait_idle(100, "after-reset");
    step_cyc(2);

    pulse_play(0, 0, "single-step");
    step_cyc(3);
    play = 1'b1;
    step_cyc(1);
    play = 1'b0;
    wait_idle(50, "single-step");
    step_cyc(3);

    $display("[TB] random phase");
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        wr_en = 1'b0;
        play = 1'b0;
        stop = 1'b0;
        reset = 1'b1;
        $display("[TB] random reset at cycle %0d", i);
        step_cyc(1);
        reset = 1'b0;
      end
      wr_en = ($urandom_range(0, 3) == 0);
      wr_ch = CW'($urandom);
      wr_addr = AW'($urandom);
      wr_data = FRAME_W'($urandom);
      play = ($urandom_range(0, 9) == 0);
      stop = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 19) == 0) loop_en = ~loop_en;
      end_step = AW'($urandom);
      step_cyc(1);
    end
    wr_en = 1'b0;
    play = 1'b0;
    stop = 1'b0;
    step_cyc(3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
